// File: rtl/mole_scheduler.sv
// mole_scheduler: whack-a-mole game sequencer.
//   Picks one of 8 holes from the lfsr value. A hole is never picked twice in a row.
//   Holds the mole up for a timed window and judges the player's buttons against it.
//   Emits one-cycle hit/miss pulses, then waits a gap before the next pick.
//
// Ports
//   CLK100MHZ   in   1  system clock, rising edge
//   reset       in   1  synchronous, active-high
//   enable      in   1  game running (level); low aborts to IDLE
//   lfsr_rand   in   3  lfsr output, sampled only in PICK (rand is a reserved word)
//   hit_btn     in   8  debounced buttons, one per hole
//   mole        out  8  one-hot visible mole, 0 when none
//   mole_idx    out  3  index of current/last mole
//   mole_valid  out  1  high while in UP
//   hit_pulse   out  1  one cycle: correct hole pressed while up
//   miss_pulse  out  1  one cycle: up window expired unhit
//   state       out  2  IDLE=0 PICK=1 UP=2 GAP=3
//
// Configuration macro: SPEEDUP_EN
//   When defined, each hit shortens the up window by SPEED_STEP ticks, down to MIN_UP_MS.
//   When undefined, the up window is always UP_MS ticks.
module mole_scheduler #(
  parameter int unsigned TICK_DIV   = 100000,
  parameter int unsigned UP_MS      = 1000,
  parameter int unsigned GAP_MS     = 500,
  parameter int unsigned MIN_UP_MS  = 250,
  parameter int unsigned SPEED_STEP = 50
) (
  input  logic       CLK100MHZ,
  input  logic       reset,
  input  logic       enable,
  input  logic [2:0] lfsr_rand,
  input  logic [7:0] hit_btn,
  output logic [7:0] mole,
  output logic [2:0] mole_idx,
  output logic       mole_valid,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic [1:0] state
);

  // Tick counter is sized by the largest tick-valued operand it is compared against.
  localparam int unsigned MAX_A    = (UP_MS > GAP_MS) ? UP_MS : GAP_MS;
  localparam int unsigned MAX_B    = (MIN_UP_MS > SPEED_STEP) ? MIN_UP_MS : SPEED_STEP;
  localparam int unsigned TICK_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned TW       = $clog2(TICK_MAX + 1);
  localparam int unsigned PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_MS - 1);
  localparam logic [TW-1:0] UP_INIT    = TW'(UP_MS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PICK = 2'd1,
    UP   = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t        st;
  logic [PW-1:0] presc;
  logic [TW-1:0] ticks;
  logic [TW-1:0] cur_up;
  logic [2:0]    pick_idx;
  logic          tick_wrap;
  logic          up_done;
  logic          gap_done;
  logic          hit_now;

  assign state = st;

  // mole_idx doubles as the last-picked index; a repeat is bumped by one (7 wraps to 0).
  assign pick_idx  = (lfsr_rand == mole_idx) ? 3'(lfsr_rand + 3'd1) : lfsr_rand;

  assign tick_wrap = (presc == PRESC_LAST);
  assign up_done   = tick_wrap && (ticks == 3'(0) + TW'(cur_up - TW'(1)));
  assign gap_done  = tick_wrap && (ticks == GAP_LAST);
  assign hit_now   = hit_btn[mole_idx];

`ifndef SPEEDUP_EN
  assign cur_up = UP_INIT;
`endif

  // Sequencer: state, counters, outputs.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      st         <= IDLE;
      presc      <= '0;
      ticks      <= '0;
      mole       <= '0;
      mole_idx   <= '0;
      mole_valid <= 1'b0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
`ifdef SPEEDUP_EN
      cur_up     <= UP_INIT;
`endif
    end else begin
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      if (!enable) begin
        // Abort: no pulse, last index kept.
        st         <= IDLE;
        presc      <= '0;
        ticks      <= '0;
        mole       <= '0;
        mole_valid <= 1'b0;
`ifdef SPEEDUP_EN
        cur_up     <= UP_INIT;
`endif
      end else begin
        case (st)
          IDLE: st <= PICK;

          PICK: begin
            mole_idx   <= pick_idx;
            mole       <= 8'd1 << pick_idx;
            mole_valid <= 1'b1;
            presc      <= '0;
            ticks      <= '0;
            st         <= UP;
          end

          UP: begin
            if (hit_now) begin
              // A hit beats expiry in the same cycle.
              hit_pulse  <= 1'b1;
              mole       <= '0;
              mole_valid <= 1'b0;
              presc      <= '0;
              ticks      <= '0;
              st         <= GAP;
`ifdef SPEEDUP_EN
              if (32'(cur_up) >= MIN_UP_MS + SPEED_STEP) begin
                cur_up <= cur_up - TW'(SPEED_STEP);
              end else begin
                cur_up <= TW'(MIN_UP_MS);
              end
`endif
            end else if (up_done) begin
              miss_pulse <= 1'b1;
              mole       <= '0;
              mole_valid <= 1'b0;
              presc      <= '0;
              ticks      <= '0;
              st         <= GAP;
            end else if (tick_wrap) begin
              presc <= '0;
              ticks <= ticks + TW'(1);
            end else begin
              presc <= presc + PW'(1);
            end
          end

          GAP: begin
            if (gap_done) begin
              presc <= '0;
              ticks <= '0;
              st    <= PICK;
            end else if (tick_wrap) begin
              presc <= '0;
              ticks <= ticks + TW'(1);
            end else begin
              presc <= presc + PW'(1);
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mole_scheduler.sv
// Self-checking bench for mole_scheduler with a countdown-based reference model.
module tb_mole_scheduler;

  localparam int TD    = 4;
  localparam int UPM   = 3;
  localparam int GAPM  = 2;
  localparam int MINUP = 1;
  localparam int STEP  = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [2:0] rnd;
  logic [7:0] hit_btn;
  logic [7:0] mole;
  logic [2:0] mole_idx;
  logic       mole_valid;
  logic       hit_pulse;
  logic       miss_pulse;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  // Reference model: phase plus cycles left in the phase.
  int   m_st;
  int   m_idx;
  int   m_valid;
  int   m_hit;
  int   m_miss;
  int   m_left;
  int   m_cur;
  logic prev_pulse;

  mole_scheduler #(
    .TICK_DIV  (TD),
    .UP_MS     (UPM),
    .GAP_MS    (GAPM),
    .MIN_UP_MS (MINUP),
    .SPEED_STEP(STEP)
  ) dut (
    .CLK100MHZ (clk),
    .reset     (reset),
    .enable    (enable),
    .lfsr_rand (rnd),
    .hit_btn   (hit_btn),
    .mole      (mole),
    .mole_idx  (mole_idx),
    .mole_valid(mole_valid),
    .hit_pulse (hit_pulse),
    .miss_pulse(miss_pulse),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(input logic rs, input logic en, input logic [2:0] rn, input logic [7:0] bt);
    m_hit  = 0;
    m_miss = 0;
    if (rs) begin
      m_st = 0; m_idx = 0; m_valid = 0; m_cur = UPM; m_left = 0;
    end else if (!en) begin
      m_st = 0; m_valid = 0; m_cur = UPM; m_left = 0;
    end else begin
      case (m_st)
        0: m_st = 1;
        1: begin
          m_idx   = (int'(rn) == m_idx) ? (m_idx + 1) % 8 : int'(rn);
          m_valid = 1;
          m_left  = m_cur * TD;
          m_st    = 2;
        end
        2: begin
          if (bt[m_idx]) begin
            m_hit   = 1;
            m_valid = 0;
            m_left  = GAPM * TD;
            m_st    = 3;
`ifdef SPEEDUP_EN
            m_cur = (m_cur >= MINUP + STEP) ? m_cur - STEP : MINUP;
`endif
          end else begin
            m_left--;
            if (m_left == 0) begin
              m_miss  = 1;
              m_valid = 0;
              m_left  = GAPM * TD;
              m_st    = 3;
            end
          end
        end
        default: begin
          m_left--;
          if (m_left == 0) m_st = 1;
        end
      endcase
    end
  endtask

  task automatic compare_all();
    logic [7:0] exp_mole;
    exp_mole = (m_valid != 0) ? (8'd1 << m_idx) : 8'd0;
    check("state", 32'(state), m_st);
    check("mole", 32'(mole), 32'(exp_mole));
    check("mole_idx", 32'(mole_idx), m_idx);
    check("mole_valid", 32'(mole_valid), m_valid);
    check("hit_pulse", 32'(hit_pulse), m_hit);
    check("miss_pulse", 32'(miss_pulse), m_miss);
    check("pulse_excl", 32'(hit_pulse & miss_pulse), 0);
    check("pulse_repeat", 32'((hit_pulse | miss_pulse) & prev_pulse), 0);
    prev_pulse = hit_pulse | miss_pulse;
  endtask

  // One clock: drive inputs, advance model on the edge, compare just after it.
  task automatic step(input logic rs, input logic en, input logic [2:0] rn, input logic [7:0] bt);
    reset   = rs;
    enable  = en;
    rnd     = rn;
    hit_btn = bt;
    @(posedge clk);
    model(rs, en, rn, bt);
    #1;
    compare_all();
  endtask

  task automatic run(input int n, input logic en, input logic [2:0] rn, input logic [7:0] bt);
    for (int i = 0; i < n; i++) step(1'b0, en, rn, bt);
  endtask

  // Advance (enabled) until the model reaches the target phase, bounded.
  task automatic go_to(input int target, input logic [2:0] rn, input logic [7:0] bt);
    int n;
    n = 0;
    while (m_st != target && n < 100) begin
      step(1'b0, 1'b1, rn, bt);
      n++;
    end
    if (m_st != target) check("go_to_timeout", 32'(m_st), target);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; rnd = 3'd0; hit_btn = 8'h00; prev_pulse = 1'b0;
    m_st = 0; m_idx = 0; m_valid = 0; m_hit = 0; m_miss = 0; m_left = 0; m_cur = UPM;

    // Reset, then first pick with rand=5.
    step(1'b1, 1'b0, 3'd5, 8'h00);
    step(1'b1, 1'b1, 3'd5, 8'h00);
    check("rst_state", 32'(state), 0);
    check("rst_mole", 32'(mole), 0);
    check("rst_idx", 32'(mole_idx), 0);
    check("rst_valid", 32'(mole_valid), 0);
    step(1'b0, 1'b1, 3'd5, 8'h00);
    check("pick_state", 32'(state), 1);
    step(1'b0, 1'b1, 3'd5, 8'h00);
    check("first_mole", 32'(mole), 32'h20);
    check("first_idx", 32'(mole_idx), 5);
    check("first_valid", 32'(mole_valid), 1);

    // Unpressed window: 12 UP cycles, miss, 8 GAP cycles.
    run(11, 1'b1, 3'd5, 8'h00);
    check("up_hold", 32'(mole_valid), 1);
    step(1'b0, 1'b1, 3'd5, 8'h00);
    check("miss_fire", 32'(miss_pulse), 1);
    check("miss_mole", 32'(mole), 0);
    run(7, 1'b1, 3'd5, 8'h00);
    check("gap_hold", 32'(state), 3);
    step(1'b0, 1'b1, 3'd5, 8'h00);
    check("gap_to_pick", 32'(state), 1);

    // Repeat avoidance and wrap.
    step(1'b0, 1'b1, 3'd5, 8'h00);
    check("repeat_bump", 32'(mole_idx), 6);
    go_to(1, 3'd7, 8'h00);
    step(1'b0, 1'b1, 3'd7, 8'h00);
    check("idx7", 32'(mole_idx), 7);
    go_to(1, 3'd7, 8'h00);
    step(1'b0, 1'b1, 3'd7, 8'h00);
    check("wrap", 32'(mole_idx), 0);

    // Hit on UP cycle 3 at hole 2.
    go_to(1, 3'd2, 8'h00);
    step(1'b0, 1'b1, 3'd2, 8'h00);
    check("idx2", 32'(mole_idx), 2);
    run(2, 1'b1, 3'd2, 8'h00);
    step(1'b0, 1'b1, 3'd2, 8'h04);
    check("hit_fire", 32'(hit_pulse), 1);
    check("hit_mole", 32'(mole), 0);
    check("hit_nomiss", 32'(miss_pulse), 0);
    check("hit_gap", 32'(state), 3);
    step(1'b0, 1'b1, 3'd2, 8'h00);
    check("hit_one_cycle", 32'(hit_pulse), 0);

    // Wrong button only: ignored, ends in miss.
    go_to(1, 3'd2, 8'h00);
    step(1'b0, 1'b1, 3'd2, 8'h00);
    check("idx3", 32'(mole_idx), 3);
    run(11, 1'b1, 3'd2, 8'h10);
    check("wrong_ignored", 32'(mole_valid), 1);
    step(1'b0, 1'b1, 3'd2, 8'h10);
    check("wrong_miss", 32'(miss_pulse), 1);
    check("wrong_nohit", 32'(hit_pulse), 0);

    // Hit on the final UP cycle beats expiry.
    go_to(1, 3'd1, 8'h00);
    step(1'b0, 1'b1, 3'd1, 8'h00);
    run(11, 1'b1, 3'd1, 8'h00);
    step(1'b0, 1'b1, 3'd1, 8'h02);
    check("last_hit", 32'(hit_pulse), 1);
    check("last_nomiss", 32'(miss_pulse), 0);
    step(1'b0, 1'b1, 3'd1, 8'h00);
    check("last_after", 32'(miss_pulse), 0);

    // Abort mid-UP (all buttons pressed), then reset mid-GAP.
    go_to(1, 3'd4, 8'h00);
    step(1'b0, 1'b1, 3'd4, 8'h00);
    run(3, 1'b1, 3'd4, 8'h00);
    step(1'b0, 1'b0, 3'd4, 8'hff);
    check("abort_state", 32'(state), 0);
    check("abort_mole", 32'(mole), 0);
    check("abort_hit", 32'(hit_pulse), 0);
    check("abort_miss", 32'(miss_pulse), 0);
    check("abort_keep_idx", 32'(mole_idx), 4);
    go_to(3, 3'd4, 8'h00);
    run(3, 1'b1, 3'd4, 8'h00);
    step(1'b1, 1'b1, 3'd4, 8'h00);
    check("rst_gap_state", 32'(state), 0);
    check("rst_gap_mole", 32'(mole), 0);
    check("rst_gap_idx", 32'(mole_idx), 0);
    check("rst_gap_valid", 32'(mole_valid), 0);
    check("rst_gap_pulses", 32'(hit_pulse | miss_pulse), 0);

    // Randomized play against the model.
    for (int i = 0; i < 3000; i++) begin
      logic       rs;
      logic       en;
      logic [7:0] bt;
      rs = ($urandom_range(0, 499) == 0);
      en = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 29) == 0) bt = 8'($urandom);
      else if ($urandom_range(0, 9) == 0) bt = 8'd1 << $urandom_range(0, 7);
      else bt = 8'h00;
      step(rs, en, 3'($urandom_range(0, 7)), bt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
